// File: rtl/fifo_word_assembler.sv
// fifo_word_assembler: drains bytes from the async FIFO read side and packs
// four consecutive bytes into a little-endian 32-bit word. Each word is then
// offered downstream on a valid/ready handshake.
// Optional feature macro: FWA_TIMEOUT_EN. When it is defined, a partial word
// is flushed after TIMEOUT_CYCLES idle cycles, and out_be marks the filled lanes.
module fifo_word_assembler (
  input  logic        rd_clk,
  input  logic        reset_n,
  input  logic        fifo_empty,
  input  logic [7:0]  fifo_data,
  output logic        fifo_rd,
  input  logic        clear,
  output logic [31:0] out_word,
  output logic [3:0]  out_be,
  output logic        out_valid,
  input  logic        out_ready
);

`ifdef FWA_TIMEOUT_EN
  // Idle cycles before a partial word is flushed; legal range 1..255.
  parameter int TIMEOUT_CYCLES = 16;
`endif

  // FILL: no word is held. HOLD: a complete or flushed word waits downstream.
  typedef enum logic {FILL = 1'b0, HOLD = 1'b1} state_t;

  state_t      state_r, state_s;
  logic [1:0]  byte_cnt_r;
  logic [31:0] work_r;
  logic [31:0] out_word_r;
  logic [3:0]  out_be_r;
  logic        rd_s;
  logic        capture_last_s;
  logic        transfer_s;
  logic        flush_s;

  assign out_valid = (state_r == HOLD);
  assign out_word  = out_word_r;
  assign out_be    = out_be_r;

  // The read strobe is gated by reset_n so the FIFO is never drained during reset.
  // It also stays low while a held word is backpressured, so at most one word is held.
  assign rd_s           = reset_n & ~fifo_empty & ~clear & (~out_valid | out_ready);
  assign fifo_rd        = rd_s;
  assign capture_last_s = rd_s & (byte_cnt_r == 2'd3);
  assign transfer_s     = out_valid & out_ready;

`ifdef FWA_TIMEOUT_EN
  logic [7:0] idle_cnt_r;
  logic       idle_s;

  // Lane-fill count to byte-enable mask for a flushed partial word.
  function automatic logic [3:0] lanes_be(input logic [1:0] cnt);
    logic [3:0] be;
    case (cnt)
      2'd1:    be = 4'h1;
      2'd2:    be = 4'h3;
      2'd3:    be = 4'h7;
      default: be = 4'h0;
    endcase
    return be;
  endfunction

  assign idle_s  = (byte_cnt_r != 2'd0) & fifo_empty & ~out_valid;
  assign flush_s = ~clear & idle_s & (idle_cnt_r == 8'(TIMEOUT_CYCLES - 1));

  // Idle counter: counts starved cycles while a partial word is pending.
  always_ff @(posedge rd_clk or negedge reset_n) begin
    if (!reset_n) begin
      idle_cnt_r <= 8'd0;
    end else if (clear || rd_s || flush_s) begin
      idle_cnt_r <= 8'd0;
    end else if (idle_s) begin
      idle_cnt_r <= idle_cnt_r + 8'd1;
    end else begin
      idle_cnt_r <= idle_cnt_r;
    end
  end
`else
  assign flush_s = 1'b0;
`endif

  // State register: FILL/HOLD mirrors out_valid.
  always_ff @(posedge rd_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= FILL;
    end else begin
      state_r <= state_s;
    end
  end

  // Next state: clear wins. A completion on a transfer edge keeps the state in HOLD.
  always_comb begin
    state_s = state_r;
    if (clear) begin
      state_s = FILL;
    end else if (capture_last_s || flush_s) begin
      state_s = HOLD;
    end else if (transfer_s) begin
      state_s = FILL;
    end else begin
      state_s = state_r;
    end
  end

  // Datapath: lane capture, word completion, flush and output-enable clearing.
  always_ff @(posedge rd_clk or negedge reset_n) begin
    if (!reset_n) begin
      byte_cnt_r <= 2'd0;
      work_r     <= 32'd0;
      out_word_r <= 32'd0;
      out_be_r   <= 4'h0;
    end else if (clear) begin
      byte_cnt_r <= 2'd0;
      work_r     <= 32'd0;
      out_word_r <= 32'd0;
      out_be_r   <= 4'h0;
    end else if (rd_s) begin
      if (byte_cnt_r == 2'd3) begin
        out_word_r <= {fifo_data, work_r[23:0]};
        out_be_r   <= 4'hF;
        work_r     <= 32'd0;
        byte_cnt_r <= 2'd0;
      end else begin
        work_r[{byte_cnt_r, 3'b000} +: 8] <= fifo_data;
        byte_cnt_r <= byte_cnt_r + 2'd1;
        if (transfer_s) begin
          out_be_r <= 4'h0;
        end else begin
          out_be_r <= out_be_r;
        end
      end
    end else if (flush_s) begin
`ifdef FWA_TIMEOUT_EN
      out_word_r <= work_r;
      out_be_r   <= lanes_be(byte_cnt_r);
      work_r     <= 32'd0;
      byte_cnt_r <= 2'd0;
`else
      out_be_r   <= out_be_r;
`endif
    end else if (transfer_s) begin
      out_be_r <= 4'h0;
    end else begin
      out_be_r <= out_be_r;
    end
  end

endmodule

// File: tb/tb_fifo_word_assembler.sv
// Self-checking bench for fifo_word_assembler. A queue stands in for the FIFO.
// A byte-list model predicts fifo_rd and the outputs on every cycle, and
// directed literal checks pin the words that were transferred.
module tb_fifo_word_assembler;

  logic        rd_clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        fifo_empty = 1'b1;
  logic [7:0]  fifo_data = 8'h00;
  logic        fifo_rd;
  logic        clear = 1'b0;
  logic [31:0] out_word;
  logic [3:0]  out_be;
  logic        out_valid;
  logic        out_ready = 1'b0;

  int checks = 0;
  int errors = 0;

  fifo_word_assembler dut (
    .rd_clk(rd_clk), .reset_n(reset_n), .fifo_empty(fifo_empty),
    .fifo_data(fifo_data), .fifo_rd(fifo_rd), .clear(clear),
    .out_word(out_word), .out_be(out_be), .out_valid(out_valid),
    .out_ready(out_ready)
  );

  always #5 rd_clk = ~rd_clk;

  // FIFO contents, model state and the log of transferred words.
  logic [7:0]  fq[$];
  logic [7:0]  part[$];
  bit          mv;
  logic [31:0] mw;
  logic [3:0]  mbe;
  int          idle;
  logic [31:0] got_w[$];
  logic [3:0]  got_be[$];
  bit          cmp_en = 1'b0;
  int          rd_cnt;
`ifdef FWA_TIMEOUT_EN
  localparam int TO = 16;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] pack_part();
    logic [31:0] w = 32'd0;
    for (int i = 0; i < part.size(); i++) w = w | (32'(part[i]) << (8 * i));
    return w;
  endfunction

  task automatic model_reset();
    part.delete();
    mv = 1'b0; mw = 32'd0; mbe = 4'h0; idle = 0;
  endtask

  // One clock edge of the behavioural model.
  task automatic model_step(input bit clr, input bit rdy, input bit rd,
                            input logic [7:0] b, input bit empty);
    bit was_valid = mv;
    if (clr) begin
      model_reset();
    end else begin
      if (mv && rdy) begin mv = 1'b0; mbe = 4'h0; end
      if (rd) begin
        part.push_back(b);
        idle = 0;
        if (part.size() == 4) begin
          mw = pack_part(); mbe = 4'hF; mv = 1'b1; part.delete();
        end
      end
`ifdef FWA_TIMEOUT_EN
      else if (part.size() != 0 && empty && !was_valid) begin
        if (idle == TO - 1) begin
          mw = pack_part(); mbe = 4'((1 << part.size()) - 1); mv = 1'b1;
          part.delete(); idle = 0;
        end else begin
          idle++;
        end
      end
`endif
    end
  endtask

  // Compare process: outputs against the model, away from the active edge.
  always @(negedge rd_clk) begin
    if (cmp_en) begin
      chk("out_valid", {31'd0, out_valid}, {31'd0, mv});
      chk("out_word", out_word, mw);
      chk("out_be", {28'd0, out_be}, {28'd0, mbe});
    end
  end

  // One cycle: drive inputs after a negedge, check fifo_rd, advance the FIFO and the model.
  task automatic step(input bit clr, input bit rdy);
    bit exp_rd, rd_seen, xfer;
    logic [31:0] w_seen;
    logic [3:0]  be_seen;
    logic [7:0]  b;
    bit          e;
    clear = clr;
    out_ready = rdy;
    fifo_empty = (fq.size() == 0);
    fifo_data = fifo_empty ? 8'h00 : fq[0];
    #1;
    exp_rd = !fifo_empty && !clr && (!mv || rdy);
    chk("fifo_rd", {31'd0, fifo_rd}, {31'd0, exp_rd});
    rd_seen = fifo_rd;
    xfer = out_valid && rdy;
    w_seen = out_word;
    be_seen = out_be;
    b = fifo_data;
    e = fifo_empty;
    @(posedge rd_clk);
    if (xfer) begin got_w.push_back(w_seen); got_be.push_back(be_seen); end
    if (rd_seen) rd_cnt++;
    model_step(clr, rdy, exp_rd, b, e);
    if (rd_seen && fq.size() > 0) void'(fq.pop_front());
    @(negedge rd_clk);
  endtask

  task automatic push_bytes(input logic [7:0] first, input int n);
    for (int i = 0; i < n; i++) fq.push_back(first + 8'(i));
  endtask

  // Asynchronous reset applied between edges; outputs must clear at once.
  task automatic do_reset(input string tag);
    #2 reset_n = 1'b0;
    #1;
    chk({tag, "_valid"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_word"}, out_word, 32'd0);
    chk({tag, "_be"}, {28'd0, out_be}, 32'd0);
    chk({tag, "_rd"}, {31'd0, fifo_rd}, 32'd0);
    cmp_en = 1'b0;
    fq.delete();
    model_reset();
    fifo_empty = 1'b1;
    repeat (2) @(negedge rd_clk);
    reset_n = 1'b1;
    cmp_en = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    repeat (3) @(negedge rd_clk);
    reset_n = 1'b1;
    cmp_en = 1'b1;
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_word", out_word, 32'd0);
    chk("rst_be", {28'd0, out_be}, 32'd0);

    // Back-to-back streaming of two words.
    for (int i = 0; i < 8; i++) fq.push_back(8'h11 * 8'(i + 1));
    got_w.delete(); got_be.delete(); rd_cnt = 0;
    repeat (8) step(1'b0, 1'b1);
    chk("t1_rd_cycles", 32'(rd_cnt), 32'd8);
    repeat (2) step(1'b0, 1'b1);
    chk("t1_count", 32'(got_w.size()), 32'd2);
    chk("t1_w0", got_w[0], 32'h44332211);
    chk("t1_w1", got_w[1], 32'h88776655);
    chk("t1_be", {28'd0, got_be[1]}, 32'hF);
    chk("t1_empty", 32'(fq.size()), 32'd0);

    // Backpressure with more bytes waiting.
    push_bytes(8'hA0, 8);
    got_w.delete(); got_be.delete();
    repeat (4) step(1'b0, 1'b0);
    rd_cnt = 0;
    repeat (10) step(1'b0, 1'b0);
    chk("t2_hold_rd", 32'(rd_cnt), 32'd0);
    chk("t2_hold_word", out_word, 32'hA3A2A1A0);
    chk("t2_hold_valid", {31'd0, out_valid}, 32'd1);
    repeat (6) step(1'b0, 1'b1);
    chk("t2_count", 32'(got_w.size()), 32'd2);
    chk("t2_w0", got_w[0], 32'hA3A2A1A0);
    chk("t2_w1", got_w[1], 32'hA7A6A5A4);

    // Empty FIFO: no read, no valid.
    rd_cnt = 0;
    for (int i = 0; i < 20; i++) step(1'b0, 1'($urandom_range(0, 1)));
    chk("t3_rd", 32'(rd_cnt), 32'd0);
    chk("t3_valid", {31'd0, out_valid}, 32'd0);

    // Clear discards a partial word.
    got_w.delete();
    push_bytes(8'hC1, 2);
    repeat (2) step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    push_bytes(8'hD0, 4);
    repeat (6) step(1'b0, 1'b1);
    chk("t4_count", 32'(got_w.size()), 32'd1);
    chk("t4_w0", got_w[0], 32'hD3D2D1D0);

    // Fourth byte arriving after 10 idle cycles completes a full word.
    got_w.delete(); got_be.delete();
    push_bytes(8'hE1, 3);
    repeat (13) step(1'b0, 1'b1);
    chk("t5_wait_valid", {31'd0, out_valid}, 32'd0);
    fq.push_back(8'hE4);
    repeat (3) step(1'b0, 1'b1);
    chk("t5_count", 32'(got_w.size()), 32'd1);
    chk("t5_w0", got_w[0], 32'hE4E3E2E1);
    chk("t5_be", {28'd0, got_be[0]}, 32'hF);
`ifdef FWA_TIMEOUT_EN
    got_w.delete(); got_be.delete();
    push_bytes(8'hE1, 3);
    repeat (20) step(1'b0, 1'b1);
    chk("t5_flush_count", 32'(got_w.size()), 32'd1);
    chk("t5_flush_w", got_w[0], 32'h00E3E2E1);
    chk("t5_flush_be", {28'd0, got_be[0]}, 32'h7);
`endif

    // Reset with two partial bytes, then reset with a held word.
    push_bytes(8'h50, 2);
    repeat (2) step(1'b0, 1'b1);
    do_reset("t6a");
    push_bytes(8'h90, 6);
    repeat (6) step(1'b0, 1'b0);
    chk("t6_pre_valid", {31'd0, out_valid}, 32'd1);
    do_reset("t6b");
    got_w.delete();
    push_bytes(8'h10, 4);
    repeat (6) step(1'b0, 1'b1);
    chk("t6_count", 32'(got_w.size()), 32'd1);
    chk("t6_w0", got_w[0], 32'h13121110);

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 2) != 0 && fq.size() < 32) fq.push_back(8'($urandom));
      step(($urandom_range(0, 24) == 0), 1'($urandom_range(0, 3) != 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
